pulse_period_meter: RTL and testbench
=====================================

Name: pulse_period_meter

Overview:
- Converts a single-bit pulse train back into a 12-bit level: the inverse direction of the level-threshold pulse generator in the same design.
- Measures the clock-cycle period between successive rising edges of i_Pulse, scales it by a prescaler, saturates it to 12 bits and presents it as o_Lv with a one-cycle valid strobe.
- A timeout flags loss of pulses.
- Sits downstream of any pulse source; feeds a 12-bit level consumer.

Parameters:
- PRESCALE, 1: clock cycles per level unit; legal range 1..65535.
- TIMEOUT_UNITS, 4095: level units without a rising edge before timeout; legal range 1..4095.

Ports:
- i_CLK  input  1  system clock, all logic on posedge.
- i_RST  input  1  synchronous, active-high reset.
- i_Pulse  input  1  pulse train, synchronous to i_CLK.
- o_Lv  output  12  last measured period in units, saturating.
- o_Valid  output  1  one-cycle strobe; o_Lv updated this cycle.
- o_Timeout  output  1  one-cycle strobe; timeout occurred this cycle.

Behaviour:
- One clock (i_CLK). Reset i_RST is synchronous and active-high, sampled on posedge i_CLK.
- Reset values: o_Lv=0, o_Valid=0, o_Timeout=0, state=IDLE, prescaler=0, unit count=0, previous-sample register=1.
  - Because the previous-sample register resets to 1, an i_Pulse held high through reset is not a rising edge.
- Rising edge: i_Pulse sampled 1 while the previous sample is 0. Only rising edges matter; pulse width and falling edges are ignored.
- States:
  - IDLE: waiting for the first edge.
  - MEASURE: counting since the last edge.
- IDLE:
  - On a rising edge, clear the prescaler and unit count and go to MEASURE.
  - No o_Valid. o_Lv holds its value.
- MEASURE, counting: the prescaler counts 0..PRESCALE-1 and wraps. Each wrap increments the unit count.
- MEASURE, on a rising edge:
  - Let N = clock cycles between the previous rising edge and this one.
  - o_Lv <= min(floor(N/PRESCALE), 4095).
  - o_Valid=1 for exactly that cycle.
  - Prescaler and unit count restart with this edge as the new reference; stay in MEASURE.
- Latency: o_Lv and o_Valid are registered; both are visible 1 clock after the posedge at which i_Pulse is first sampled high.
- Timeout:
  - Fires in MEASURE when floor(N/PRESCALE) would exceed TIMEOUT_UNITS with no rising edge, i.e. N reaches (TIMEOUT_UNITS+1)*PRESCALE.
  - Outputs: o_Lv <= 4095, o_Valid=1 and o_Timeout=1 for one cycle.
  - Transitions to IDLE; the next rising edge only re-arms and produces no measurement.
- Simultaneous rising edge and timeout condition in the same cycle: the edge wins. A normal measurement is reported, with no o_Timeout and no IDLE transition.
- Saturation: the unit count never wraps; it stops at 4095 (width 12). Internal counters are sized for (TIMEOUT_UNITS+1)*PRESCALE without overflow.
- Reset mid-measurement: the next cycle shows all reset values. The partial period is discarded and no strobe is emitted.
- o_Valid and o_Timeout are never high for more than one consecutive cycle.
- Back-to-back rising edges are possible (minimum N=2, alternating input). With PRESCALE=1 they give o_Lv=2 on each edge.

Test Plan:
- PRESCALE=1, reset, then rising edges 10 cycles apart, repeated 3 times -> after the first edge no strobe; then o_Valid pulses one cycle after each subsequent edge with o_Lv=10.
- PRESCALE=4, rising edges 10 cycles apart, then 17 cycles apart -> o_Lv=2, then o_Lv=4; o_Timeout stays 0.
- PRESCALE=1, TIMEOUT_UNITS=100, one edge then i_Pulse held low -> o_Timeout=o_Valid=1 for one cycle after 101 cycles, o_Lv=4095, state IDLE. The next edge gives no strobe; an edge 5 cycles later gives o_Lv=5.
- PRESCALE=1, TIMEOUT_UNITS=4095, edges 5000 cycles apart -> timeout at 4096; the edge at 5000 only re-arms; no wrap-around value ever appears on o_Lv.
- i_Pulse held high across reset release, then low 3 cycles, high again -> no strobe for the held-high level; the first counted edge is the later one.
- Edges 10 apart, assert i_RST 4 cycles into the next period, release, then edge -> o_Lv=0 and o_Valid=0 after reset; that edge only arms measurement.

Source files
------------

// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures the period between rising edges of i_Pulse in prescaled units, saturating to 12 bits, and flags loss of pulses
module pulse_period_meter #(
    parameter int PRESCALE      = 1,
    parameter int TIMEOUT_UNITS = 4095
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_Pulse,
    output logic [11:0] o_Lv,
    output logic        o_Valid,
    output logic        o_Timeout
);
    typedef enum logic {IDLE, MEASURE} state_t;
    state_t      state, state_d;
    logic        pulse_q;
    logic [15:0] presc;
    logic [11:0] units;
    logic        rise, wrap, tmo_hit, do_meas, do_tmo;
    logic [12:0] meas;
    // edge detection, period-in-units of the current cycle and next state
    always_comb begin
        rise    = i_Pulse & ~pulse_q;
        wrap    = presc == 16'(PRESCALE - 1);
        meas    = {1'b0, units} + 13'(wrap);
        tmo_hit = meas > 13'(TIMEOUT_UNITS);
        do_meas = state == MEASURE && rise;
        do_tmo  = state == MEASURE && !rise && tmo_hit;
        state_d = state == IDLE ? (rise ? MEASURE : IDLE) : (do_tmo ? IDLE : MEASURE);
    end
    // state register
    always_ff @(posedge i_CLK) begin
        if (i_RST) state <= IDLE;
        else       state <= state_d;
    end
    // counters, edge history and registered outputs
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            pulse_q   <= 1'b1;
            presc     <= '0;
            units     <= '0;
            o_Lv      <= '0;
            o_Valid   <= 1'b0;
            o_Timeout <= 1'b0;
        end else begin
            pulse_q   <= i_Pulse;
            o_Valid   <= do_meas | do_tmo;
            o_Timeout <= do_tmo;
            if (do_meas)     o_Lv <= meas[12] ? 12'hFFF : meas[11:0];
            else if (do_tmo) o_Lv <= 12'hFFF;
            if (rise) begin
                presc <= '0;
                units <= '0;
            end else if (state == MEASURE) begin
                presc <= wrap ? 16'd0 : presc + 16'd1;
                units <= (wrap && units != 12'hFFF) ? units + 12'd1 : units;
            end
        end
    end
endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter: three meters with different prescale/timeout settings checked against an edge-time model
module tb_pulse_period_meter;
    logic clk = 1'b0, rst = 1'b1, pulse = 1'b0;
    always #5 clk = ~clk;
    localparam int P[3] = '{1, 4, 1};
    localparam int T[3] = '{4095, 4095, 100};
    logic [11:0] lv [3];
    logic        v  [3];
    logic        to [3];
    pulse_period_meter #(.PRESCALE(1), .TIMEOUT_UNITS(4095)) d0 (.i_CLK(clk), .i_RST(rst), .i_Pulse(pulse), .o_Lv(lv[0]), .o_Valid(v[0]), .o_Timeout(to[0]));
    pulse_period_meter #(.PRESCALE(4), .TIMEOUT_UNITS(4095)) d1 (.i_CLK(clk), .i_RST(rst), .i_Pulse(pulse), .o_Lv(lv[1]), .o_Valid(v[1]), .o_Timeout(to[1]));
    pulse_period_meter #(.PRESCALE(1), .TIMEOUT_UNITS(100))  d2 (.i_CLK(clk), .i_RST(rst), .i_Pulse(pulse), .o_Lv(lv[2]), .o_Valid(v[2]), .o_Timeout(to[2]));

    int cyc = 0;
    int tref [3];
    bit armed [3];
    bit prev = 1'b1;
    bit live = 1'b0;
    int m_lv [3];
    bit m_v  [3];
    bit m_to [3];
    // model: remember the cycle of the last counted edge and derive outputs from elapsed cycles
    always @(posedge clk) begin : mdl
        int n;
        bit rise;
        rise = pulse && !prev;
        for (int k = 0; k < 3; k++) begin
            n = cyc - tref[k];
            if (rst) begin
                armed[k] <= 1'b0; m_lv[k] <= 0; m_v[k] <= 1'b0; m_to[k] <= 1'b0;
            end else if (rise && armed[k]) begin
                m_lv[k] <= (n / P[k] > 4095) ? 4095 : n / P[k];
                m_v[k] <= 1'b1; m_to[k] <= 1'b0; tref[k] <= cyc;
            end else if (rise) begin
                armed[k] <= 1'b1; tref[k] <= cyc; m_v[k] <= 1'b0; m_to[k] <= 1'b0;
            end else if (armed[k] && n >= (T[k] + 1) * P[k]) begin
                m_lv[k] <= 4095; m_v[k] <= 1'b1; m_to[k] <= 1'b1; armed[k] <= 1'b0;
            end else begin
                m_v[k] <= 1'b0; m_to[k] <= 1'b0;
            end
        end
        prev <= rst ? 1'b1 : pulse;
        cyc  <= cyc + 1;
        if (rst) live <= 1'b1;
    end

    int pin_seq [3] = '{0, 0, 0};
    int pin_lv  [3];
    int pin_v   [3];
    int pin_to  [3];
    string pin_nm [3];
    int seen [3] = '{0, 0, 0};
    int checks = 0, errors = 0;
    // compare every DUT against the model each cycle, plus any hand-computed pins posted this cycle
    always @(negedge clk) begin
        if (live) begin
            for (int k = 0; k < 3; k++) begin
                checks = checks + 1;
                if (lv[k] !== 12'(m_lv[k]) || v[k] !== m_v[k] || to[k] !== m_to[k]) begin
                    errors = errors + 1;
                    $display("FAIL model d%0d cyc=%0d: got lv=%0d v=%0b to=%0b, want lv=%0d v=%0b to=%0b",
                             k, cyc, lv[k], v[k], to[k], m_lv[k], m_v[k], m_to[k]);
                end
                if (pin_seq[k] != seen[k]) begin
                    seen[k] = pin_seq[k];
                    checks = checks + 2;
                    if (lv[k] !== 12'(pin_lv[k]) || v[k] !== pin_v[k][0] || to[k] !== pin_to[k][0]) begin
                        errors = errors + 1;
                        $display("FAIL %s d%0d: got lv=%0d v=%0b to=%0b, want lv=%0d v=%0d to=%0d",
                                 pin_nm[k], k, lv[k], v[k], to[k], pin_lv[k], pin_v[k], pin_to[k]);
                    end
                    if (m_lv[k] != pin_lv[k] || m_v[k] != pin_v[k][0] || m_to[k] != pin_to[k][0]) begin
                        errors = errors + 1;
                        $display("FAIL %s model-pin d%0d: model lv=%0d v=%0b to=%0b, want lv=%0d v=%0d to=%0d",
                                 pin_nm[k], k, m_lv[k], m_v[k], m_to[k], pin_lv[k], pin_v[k], pin_to[k]);
                    end
                end
            end
        end
    end

    task automatic step(input bit p);
        pulse = p;
        @(posedge clk);
        #1;
    endtask
    task automatic low(input int n);
        repeat (n) step(1'b0);
    endtask
    task automatic pin(input int k, input int elv, input int ev, input int eto, input string nm);
        pin_lv[k] = elv; pin_v[k] = ev; pin_to[k] = eto; pin_nm[k] = nm;
        pin_seq[k] = pin_seq[k] + 1;
    endtask
    task automatic pin_all(input int l0, input int l1, input int l2, input int ev, input string nm);
        pin(0, l0, ev, 0, nm); pin(1, l1, ev, 0, nm); pin(2, l2, ev, 0, nm);
    endtask

    initial begin
        rst = 1'b1;
        low(3);
        pin_all(0, 0, 0, 0, "reset");
        rst = 1'b0;
        low(2);
        step(1'b1); pin_all(0, 0, 0, 0, "first_edge");
        low(9); step(1'b1); pin_all(10, 2, 10, 1, "gap10_a");
        low(9); step(1'b1); pin_all(10, 2, 10, 1, "gap10_b");
        low(16); step(1'b1); pin_all(17, 4, 17, 1, "gap17");
        step(1'b0); pin_all(17, 4, 17, 0, "strobe_one_cycle");
        low(99); pin(2, 17, 0, 0, "pre_timeout");
        step(1'b0); pin(2, 4095, 1, 1, "timeout101");
        step(1'b0); pin(2, 4095, 0, 0, "timeout_one_cycle");
        low(7); step(1'b1);
        pin(0, 110, 1, 0, "gap110"); pin(1, 27, 1, 0, "gap110_p4"); pin(2, 4095, 0, 0, "rearm_only");
        low(4); step(1'b1); pin_all(5, 1, 5, 1, "gap5");
        step(1'b0); step(1'b1); pin_all(2, 0, 2, 1, "back_to_back");
        low(4095); pin(0, 2, 0, 0, "n4095_no_timeout");
        step(1'b0); pin(0, 4095, 1, 1, "timeout4096");
        low(903); step(1'b1);
        pin(0, 4095, 0, 0, "rearm_5000"); pin(1, 1250, 1, 0, "gap5000_p4"); pin(2, 4095, 0, 0, "rearm_5000_t100");
        rst = 1'b1;
        repeat (3) step(1'b1);
        rst = 1'b0;
        repeat (3) step(1'b1);
        pin_all(0, 0, 0, 0, "held_high_reset");
        low(3); step(1'b1); pin_all(0, 0, 0, 0, "held_high_first_edge");
        low(9); step(1'b1); pin_all(10, 2, 10, 1, "held_high_gap10");
        low(9); step(1'b1); pin_all(10, 2, 10, 1, "pre_reset_gap10");
        low(4);
        rst = 1'b1;
        low(2);
        rst = 1'b0;
        pin_all(0, 0, 0, 0, "mid_reset");
        low(3); step(1'b1); pin_all(0, 0, 0, 0, "post_reset_arm");
        low(9); step(1'b1); pin_all(10, 2, 10, 1, "post_reset_gap10");
        low(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
